// File: rtl/lms_pkg.sv
// Shared widths, sample type and the output/weight limiter for the LMS noise canceller.
// LMS_SATURATE_EN selects clamping in sat16; without it sat16 wraps to the low 16 bits.
package lms_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned PW  = 32;
  localparam int unsigned QF  = 15;
  localparam int unsigned SW  = 48;           // common argument width for sat16
  localparam int unsigned MPW = 2 * DW + 1;   // unsigned step (as 17b signed) times error
  localparam int unsigned MUW = MPW - QF;     // mu_e width after the Q15 shift
  localparam int unsigned UPW = MUW + DW;     // mu_e times a captured reference sample

  localparam logic signed [SW-1:0] SAT_MAX = 48'sd32767;
  localparam logic signed [SW-1:0] SAT_MIN = -48'sd32768;

  typedef logic signed [DW-1:0] sample_t;

  function automatic sample_t sat16(input logic signed [SW-1:0] v);
`ifdef LMS_SATURATE_EN
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end
    return sample_t'(DW'(v));
`else
    return sample_t'(DW'(v));
`endif
  endfunction

endpackage

// File: rtl/lms_filter_top_tap.sv
// One adaptive FIR tap: reference delay stage, captured sample, weight and its product.
module lms_tap
  import lms_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  shift_en_i,
  input  sample_t               x_i,
  input  logic                  cap_en_i,
  input  logic                  upd_en_i,
  input  logic signed [MUW-1:0] mu_e_i,
  output sample_t               x_o,
  output logic signed [PW-1:0]  prod_c_o
);

  sample_t x_q;
  sample_t xs_q;
  sample_t w_q;
  sample_t w_d;

  logic signed [UPW-1:0]    upd_full;
  logic signed [UPW-QF-1:0] upd;

  // Weight step uses the sample captured with the iteration that produced the error.
  always_comb begin
    upd_full = UPW'(mu_e_i) * UPW'(xs_q);
    upd      = (UPW - QF)'(upd_full >>> QF);
    w_d      = sat16(SW'(w_q) + SW'(upd));
  end

  assign prod_c_o = PW'(w_q) * PW'(x_q);
  assign x_o      = x_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      xs_q <= '0;
      w_q  <= '0;
    end else begin
      if (shift_en_i) x_q  <= x_i;
      if (cap_en_i)   xs_q <= x_q;
      if (upd_en_i)   w_q  <= w_d;
    end
  end

endmodule

// File: rtl/lms_filter_top.sv
// Two-stage delayed-LMS noise canceller: FIR of the reference stream subtracted from the ADC sample.
// Build option LMS_SATURATE_EN: clamp (defined) or wrap (undefined) every 16-bit result.
module lms_filter_top
  import lms_pkg::*;
#(
  parameter logic [15:0] Step_size = 16'h000F,
  parameter int unsigned TAPS      = 8
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [15:0] adc_data,
  input  logic        rec_en,
  input  logic [31:0] rec_data,
  output logic [15:0] y_lms
);

  localparam int unsigned AW = PW + $clog2(TAPS);

  sample_t               x_out [TAPS];
  logic signed [PW-1:0]  prod  [TAPS];

  logic signed [AW-1:0]  acc_d;
  logic signed [AW-1:0]  acc_q;
  sample_t               d_r_q;
  logic                  v1_q;
  sample_t               y_lms_q;

  sample_t               y_c;
  sample_t               e_c;
  logic signed [MPW-1:0] mu_full;
  logic signed [MUW-1:0] mu_e;

  logic                  unused_bits;
  assign unused_bits = ^{rec_data[31:16], x_out[TAPS-1]};

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    sample_t x_in;
    if (k == 0) begin : g_head
      assign x_in = sample_t'(rec_data[DW-1:0]);
    end else begin : g_body
      assign x_in = x_out[k-1];
    end

    lms_tap u_tap (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .shift_en_i (rec_en),
      .x_i        (x_in),
      .cap_en_i   (data_valid),
      .upd_en_i   (v1_q),
      .mu_e_i     (mu_e),
      .x_o        (x_out[k]),
      .prod_c_o   (prod[k])
    );
  end

  // Full-precision sum of the tap products; cannot overflow at AW bits.
  always_comb begin
    acc_d = '0;
    for (int k = 0; k < int'(TAPS); k++) begin
      acc_d = acc_d + AW'(prod[k]);
    end
  end

  always_comb begin
    y_c     = sat16(SW'(acc_q >>> QF));
    e_c     = sat16(SW'(d_r_q) - SW'(y_c));
    mu_full = MPW'($signed({1'b0, Step_size})) * MPW'(e_c);
    mu_e    = MUW'(mu_full >>> QF);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      d_r_q   <= '0;
      v1_q    <= 1'b0;
      y_lms_q <= '0;
    end else begin
      v1_q <= data_valid;
      if (data_valid) begin
        acc_q <= acc_d;
        d_r_q <= sample_t'(adc_data);
      end
      if (v1_q) y_lms_q <= e_c;
    end
  end

  assign y_lms = y_lms_q;

endmodule

// File: tb/tb_lms_filter_top.sv
// Bench for lms_filter_top: two instances (default step and a faster step) against an arithmetic model.
module tb_lms_filter_top;

  localparam int TAPS = 8;

  logic        sys_clk;
  logic        rst_n;
  logic        data_valid;
  logic [15:0] adc_data;
  logic        rec_en;
  logic [31:0] rec_data;
  logic [15:0] y_lms;
  logic [15:0] y_lms_f;

  int n_checks;
  int n_errors;

  lms_filter_top #(.Step_size(16'h000F), .TAPS(TAPS)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .data_valid(data_valid), .adc_data(adc_data),
    .rec_en(rec_en), .rec_data(rec_data), .y_lms(y_lms)
  );

  lms_filter_top #(.Step_size(16'h1000), .TAPS(TAPS)) dut_f (
    .sys_clk(sys_clk), .rst_n(rst_n), .data_valid(data_valid), .adc_data(adc_data),
    .rec_en(rec_en), .rec_data(rec_data), .y_lms(y_lms_f)
  );

  logic [15:0] w_obs [TAPS];
  for (genvar g = 0; g < TAPS; g++) begin : g_w
    assign w_obs[g] = dut.g_tap[g].u_tap.w_q;
  end

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Reference model: index 0 = default step, index 1 = fast step.
  longint mstep [2] = '{15, 4096};
  longint mx  [2][TAPS];
  longint mxs [2][TAPS];
  longint mw  [2][TAPS];
  longint macc [2];
  longint mdr  [2];
  longint my   [2];
  bit     mv1  [2];

  function automatic longint sat(input longint v);
`ifdef LMS_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
`endif
  endfunction

  function automatic longint s16(input logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic int abs16(input logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return (t < 0) ? -int'(t) : int'(t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < TAPS; k++) begin
        mx[i][k] = 0; mxs[i][k] = 0; mw[i][k] = 0;
      end
      macc[i] = 0; mdr[i] = 0; my[i] = 0; mv1[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic dv, input logic [15:0] d, input logic re, input logic [15:0] rd);
    longint nw [TAPS];
    longint yy, e, mu, s;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < TAPS; k++) nw[k] = mw[i][k];
      if (mv1[i]) begin
        yy = sat(macc[i] >>> 15);
        e  = sat(mdr[i] - yy);
        my[i] = e;
        mu = (mstep[i] * e) >>> 15;
        for (int k = 0; k < TAPS; k++) nw[k] = sat(mw[i][k] + ((mu * mxs[i][k]) >>> 15));
      end
      if (dv) begin
        s = 0;
        for (int k = 0; k < TAPS; k++) s += mw[i][k] * mx[i][k];
        macc[i] = s;
        for (int k = 0; k < TAPS; k++) mxs[i][k] = mx[i][k];
        mdr[i] = s16(d);
      end
      mv1[i] = dv;
      if (re) begin
        for (int k = TAPS - 1; k > 0; k--) mx[i][k] = mx[i][k-1];
        mx[i][0] = s16(rd);
      end
      for (int k = 0; k < TAPS; k++) mw[i][k] = nw[k];
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    if (!rst_n) model_reset();
    else model_edge(data_valid, adc_data, rec_en, rec_data[15:0]);
    #1;
  endtask

  task automatic idle();
    data_valid = 1'b0; rec_en = 1'b0; adc_data = '0; rec_data = '0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic prefill(input logic [15:0] v);
    for (int i = 0; i < TAPS; i++) begin
      rec_en = 1'b1; rec_data = {16'h0, v};
      tick();
    end
    rec_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      data_valid = 1'($urandom); rec_en = 1'($urandom);
      adc_data = 16'($urandom); rec_data = $urandom;
      tick();
      n_checks++;
      if (y_lms !== 16'h0 || y_lms_f !== 16'h0) begin
        n_errors++;
        $display("FAIL reset_hold: got %h/%h expected 0000", y_lms, y_lms_f);
      end
    end
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (y_lms !== 16'h0 || y_lms_f !== 16'h0) begin
        n_errors++;
        $display("FAIL reset_idle: got %h/%h expected 0000", y_lms, y_lms_f);
      end
    end
  endtask

  task automatic test_pass_through();
    apply_reset();
    adc_data = 16'h1234; data_valid = 1'b1;
    tick();
    idle();
    n_checks++;
    if (y_lms !== 16'h0) begin
      n_errors++;
      $display("FAIL pass_latency: got %h expected 0000", y_lms);
    end
    tick();
    n_checks++;
    if (y_lms !== 16'h1234) begin
      n_errors++;
      $display("FAIL pass_through: got %h expected 1234", y_lms);
    end
    for (int k = 0; k < TAPS; k++) begin
      n_checks++;
      if (w_obs[k] !== 16'h0) begin
        n_errors++;
        $display("FAIL pass_weight[%0d]: got %h expected 0000", k, w_obs[k]);
      end
    end
    tick();
    tick();
    n_checks++;
    if (y_lms !== 16'h1234) begin
      n_errors++;
      $display("FAIL pass_hold: got %h expected 1234", y_lms);
    end
  endtask

  task automatic single_update_scenario(input string tag);
    prefill(16'h4000);
    data_valid = 1'b1; adc_data = 16'h4000;
    tick();
    idle();
    tick();
    n_checks++;
    if (y_lms !== 16'h4000 || y_lms !== 16'(my[0])) begin
      n_errors++;
      $display("FAIL %s_first: got %h expected 4000 (model %h)", tag, y_lms, 16'(my[0]));
    end
    for (int k = 0; k < TAPS; k++) begin
      n_checks++;
      if (w_obs[k] !== 16'd3) begin
        n_errors++;
        $display("FAIL %s_weight[%0d]: got %h expected 0003", tag, k, w_obs[k]);
      end
    end
    data_valid = 1'b1; adc_data = 16'h4000;
    tick();
    idle();
    tick();
    n_checks++;
    if (y_lms !== 16'h3FF4 || y_lms !== 16'(my[0])) begin
      n_errors++;
      $display("FAIL %s_second: got %h expected 3ff4 (model %h)", tag, y_lms, 16'(my[0]));
    end
  endtask

  task automatic test_single_update();
    apply_reset();
    single_update_scenario("single");
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      data_valid = 1'($urandom); rec_en = 1'($urandom);
      adc_data = 16'($urandom); rec_data = $urandom;
      tick();
      n_checks++;
      if (y_lms !== 16'(my[0]) || y_lms_f !== 16'(my[1])) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h/%h expected %h/%h", i, y_lms, y_lms_f, 16'(my[0]), 16'(my[1]));
      end
    end
    idle();
  endtask

  task automatic test_convergence();
    int prev;
    int cur;
    bit started;
    apply_reset();
    prefill(16'h4000);
    data_valid = 1'b1; rec_en = 1'b1; adc_data = 16'h4000; rec_data = 32'h0000_4000;
    started = 1'b0;
    prev = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cur = abs16(y_lms_f);
      if (started) begin
        n_checks++;
        if (cur > prev) begin
          n_errors++;
          $display("FAIL conv_monotonic[%0d]: got |e|=%0d expected <= %0d", i, cur, prev);
        end
      end
      if (y_lms_f != 16'h0) started = 1'b1;
      prev = cur;
      n_checks++;
      if (y_lms !== 16'(my[0]) || y_lms_f !== 16'(my[1])) begin
        n_errors++;
        $display("FAIL conv_model[%0d]: got %h/%h expected %h/%h", i, y_lms, y_lms_f, 16'(my[0]), 16'(my[1]));
      end
    end
    idle();
    n_checks++;
    if (abs16(y_lms_f) > 16) begin
      n_errors++;
      $display("FAIL conv_final: got |e|=%0d expected <= 16", abs16(y_lms_f));
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    prefill(16'h4000);
    data_valid = 1'b1; rec_en = 1'b1; adc_data = 16'h7FFF; rec_data = 32'h0000_4000;
    for (int i = 0; i < 300; i++) tick();
    idle();
    tick();
    tick();
    n_checks++;
    if (y_lms_f !== 16'(my[1]) || abs16(y_lms_f) > 16) begin
      n_errors++;
      $display("FAIL sat_converged: got %h expected %h", y_lms_f, 16'(my[1]));
    end
    data_valid = 1'b1; adc_data = 16'h8000;
    tick();
    idle();
    tick();
    n_checks++;
    if (y_lms_f !== 16'(my[1]) || y_lms !== 16'(my[0])) begin
      n_errors++;
      $display("FAIL sat_model: got %h/%h expected %h/%h", y_lms, y_lms_f, 16'(my[0]), 16'(my[1]));
    end
`ifdef LMS_SATURATE_EN
    n_checks++;
    if (y_lms_f !== 16'h8000) begin
      n_errors++;
      $display("FAIL sat_clamp: got %h expected 8000", y_lms_f);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      data_valid = 1'b1; rec_en = 1'($urandom);
      adc_data = 16'($urandom); rec_data = $urandom;
      tick();
    end
    @(negedge sys_clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (y_lms !== 16'h0 || y_lms_f !== 16'h0) begin
      n_errors++;
      $display("FAIL midreset_out: got %h/%h expected 0000", y_lms, y_lms_f);
    end
    for (int k = 0; k < TAPS; k++) begin
      n_checks++;
      if (w_obs[k] !== 16'h0) begin
        n_errors++;
        $display("FAIL midreset_weight[%0d]: got %h expected 0000", k, w_obs[k]);
      end
    end
    tick();
    idle();
    tick();
    rst_n = 1'b1;
    single_update_scenario("midreset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_pass_through();
    test_single_update();
    test_random();
    test_convergence();
    test_saturation();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lms_filter_top.md
# lms_filter_top

Single-clock adaptive LMS noise canceller. Reference-noise samples from the network receive path (`rec_data`/`rec_en`) feed an N-tap adaptive FIR. Its output is subtracted from the microphone/ADC sample (`adc_data`/`data_valid`). The error signal is the cleaned audio output `y_lms` and also drives the weight update. It sits after the clock-domain crossings: both input streams arrive already synchronous to `sys_clk`.

## Interface
- `Step_size`, default 16'h000F: LMS step μ, unsigned Q0.15.
- `TAPS`, default 8: filter length, 2..32.
- `sys_clk`  input  1: the only clock; all logic on its rising edge.
- `rst_n`  input  1: reset, asynchronous assert, active-low.
- `data_valid`  input  1: `adc_data` holds a valid sample this cycle; one LMS iteration per high cycle.
- `adc_data`  input  16: desired signal d, signed Q1.15.
- `rec_en`  input  1: `rec_data` holds a valid reference sample this cycle.
- `rec_data`  input  32: reference x; bits [15:0] used as signed Q1.15, bits [31:16] ignored.
- `y_lms`  output  16: error e = d − y, signed Q1.15, registered.

## Operation
- Reference delay line `x[0..TAPS-1]`: on each cycle with `rec_en` high, `x[0] <= rec_data[15:0]` and `x[k] <= x[k-1]`. Otherwise the line holds.
- Weights `w[0..TAPS-1]` are signed 16-bit Q1.15.
- Stage 1, on each edge with `data_valid` high:
  - `d_r <= adc_data`.
  - `xs[k] <= x[k]`, using the pre-shift values of the same edge.
  - `acc <= Σ w[k]·x[k]`, a 32-bit product per tap, summed at width 32+ceil(log2 TAPS).
  - `v1 <= 1`.
- Stage 2, on each edge with `v1` high:
  - `y = acc >>> 15`, saturated to 16 bits.
  - `e = d_r − y`, computed at 17 bits, saturated to 16 bits.
  - `y_lms <= e`.
  - Weight update: `w[k] <= sat16(w[k] + ((((Step_size·e) >>> 15)·xs[k]) >>> 15))`, with arithmetic shifts that floor toward −∞.
- Delayed LMS, delay 1: an accumulation at edge T+1 uses the weights from before the update made at edge T+1.
- `y_lms` holds its value between iterations.
- Reset: `y_lms` = 0, all `w` = 0, all `x` and `xs` = 0, `acc` = 0, `d_r` = 0, `v1` = 0. With zero weights the block passes `d` through unchanged.
- `rec_en` and `data_valid` high in the same cycle: the iteration uses the old delay line, and the shift still happens.

## Timing
- Latency: `data_valid` sampled at edge T, `y_lms` updated at edge T+1. Weights also update at T+1.
- Throughput: one iteration per clock; `data_valid` may stay high continuously.
- No backpressure and no output valid strobe.
- Reset mid-operation clears all state immediately, including any in-flight stage-1 result. The first iteration after release behaves exactly like the first after power-up.

## Configuration
- Macro `LMS_SATURATE_EN`.
- Defined: every `sat16` above clamps to [0x8000, 0x7FFF].
- Undefined: every `sat16` becomes plain truncation to the low 16 bits, two's-complement wrap.
- Nothing else changes.

## Structure
- Package `lms_pkg` holds:
  - width constants: `DW`=16, `PW`=32, `QF`=15;
  - the `sat16` function, which honours `LMS_SATURATE_EN`;
  - the `sample_t` signed-16 typedef.
- Sub-module `lms_tap`, instantiated `TAPS` times. Each holds one `x`, `xs` and `w` stage and produces its product. It takes `mu_e` = `(Step_size·e)>>>15` broadcast from the top level.
- The top level owns the adder tree, `d_r`, the error computation and `y_lms`.

## Test plan
- Reset: with `rst_n` low, drive random inputs. Expect `y_lms`=0. After release with no valid strobes, `y_lms` stays 0.
- Pass-through: `rec_en`=0, one `data_valid` pulse with `adc_data`=0x1234. Expect `y_lms`=0x1234 one edge later and all weights still 0.
- Single update, `TAPS`=8, `Step_size`=0x000F:
  - Stimulus: pulse `rec_en` 8 times with 0x4000, then pulse `data_valid` once with d=0x4000.
  - Expected: `y_lms`=0x4000. Every `w[k]` = (15·0x4000>>>15 = 7)·0x4000>>>15 = 3.
  - A second pulse gives `y_lms`=0x4000−12=0x3FF4.
- Convergence: hold `rec_en` and `data_valid` high with x=d=0x4000. Expect |`y_lms`| to fall monotonically to within 0x0010 of 0 within 2000 cycles.
- Saturation, with `LMS_SATURATE_EN` defined:
  - Stimulus: force weights so y≈+1.0 (x=0x7FFF), then d=0x8000.
  - Expected: `y_lms`=0x8000 (clamped). Without the macro, the result wraps to the low 16 bits.
- Reset mid-run: assert `rst_n` during continuous operation. Expect `y_lms` and all weights at 0 immediately. After release, the single-update scenario reproduces exactly.
